// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl: host-side sequencer for the byte-wide RSA core.
// Streams 96 operand bytes (base, exponent, modulus) into the core, pulses
// start, waits for completion, then reads the 32 result bytes back out as a
// valid/ready stream with a last marker.
// Build option: define RSA_HOST_BIG_ENDIAN_EN to treat every 32-byte
// segment (and the result) as big-endian on the byte streams.
module rsa_host_ctrl #(
    parameter int LAT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic [LAT_W-1:0] lat_cycles,
    output logic             core_we,
    output logic             core_oe,
    output logic             core_start,
    output logic [1:0]       core_reg_sel,
    output logic [4:0]       core_addr,
    output logic [7:0]       core_wdata,
    input  logic [7:0]       core_rdata,
    input  logic             core_ready
);

    typedef enum logic [2:0] {
        LOAD, START, WAIT_LO, WAIT_DONE, RD_ADDR, RD_CAP, RD_OUT, RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [6:0]       wr_cnt_reg, wr_cnt_next;
    logic [4:0]       rd_cnt_reg, rd_cnt_next;
    logic             out_valid_reg, out_valid_next;
    logic [7:0]       out_data_reg, out_data_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [LAT_W-1:0] lat_cycles_reg, lat_cycles_next;
    logic [LAT_W-1:0] lat_inc;
    logic [4:0]       wr_addr;
    logic [4:0]       rd_addr;
    logic             in_hs;

`ifdef RSA_HOST_BIG_ENDIAN_EN
    // First stream byte of a segment is the most significant one.
    assign wr_addr = 5'd31 - wr_cnt_reg[4:0];
    assign rd_addr = 5'd31 - rd_cnt_reg;
`else
    assign wr_addr = wr_cnt_reg[4:0];
    assign rd_addr = rd_cnt_reg;
`endif

    // Segment index 0/1/2 maps onto register selects 01/10/11.
    assign core_reg_sel = wr_cnt_reg[6:5] + 2'd1;

    // Latency counter holds at all-ones instead of wrapping.
    assign lat_inc = (&lat_cnt_reg) ? lat_cnt_reg : lat_cnt_reg + LAT_W'(1);

    assign in_hs      = in_valid & in_ready;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_valid_reg & (state_reg == RD_OUT) & (rd_cnt_reg == 5'd31);
    assign lat_cycles = lat_cycles_reg;
    assign busy       = (state_reg != LOAD);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= LOAD;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            lat_cnt_reg    <= '0;
            lat_cycles_reg <= '0;
        end else begin
            state_reg      <= state_next;
            wr_cnt_reg     <= wr_cnt_next;
            rd_cnt_reg     <= rd_cnt_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            lat_cnt_reg    <= lat_cnt_next;
            lat_cycles_reg <= lat_cycles_next;
        end
    end

    // Next-state logic and core strobes.
    always_comb begin
        state_next      = state_reg;
        wr_cnt_next     = wr_cnt_reg;
        rd_cnt_next     = rd_cnt_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        lat_cnt_next    = lat_cnt_reg;
        lat_cycles_next = lat_cycles_reg;
        in_ready        = 1'b0;
        core_we         = 1'b0;
        core_oe         = 1'b0;
        core_start      = 1'b0;
        core_addr       = 5'd0;
        core_wdata      = 8'h00;

        case (state_reg)
            LOAD: begin
                // A dropped core_ready blocks the handshake, so no write slips through.
                in_ready   = core_ready;
                core_we    = in_hs;
                core_wdata = in_hs ? in_data : 8'h00;
                core_addr  = wr_addr;
                if (in_hs) begin
                    if (wr_cnt_reg == 7'd95) begin
                        wr_cnt_next = '0;
                        state_next  = START;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 7'd1;
                    end
                end
            end
            START: begin
                // The START cycle itself counts, hence restarting at one.
                core_start   = 1'b1;
                lat_cnt_next = LAT_W'(1);
                state_next   = WAIT_LO;
            end
            WAIT_LO: begin
                lat_cnt_next = lat_inc;
                if (!core_ready) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                lat_cnt_next = lat_inc;
                if (core_ready) begin
                    lat_cycles_next = lat_cnt_reg;
                    state_next      = RD_ADDR;
                end
            end
            RD_ADDR: begin
                core_oe    = 1'b1;
                core_addr  = rd_addr;
                state_next = RD_CAP;
            end
            RD_CAP: begin
                // Core output register now holds the byte addressed last cycle.
                core_oe        = 1'b1;
                core_addr      = rd_addr;
                out_data_next  = core_rdata;
                out_valid_next = 1'b1;
                state_next     = RD_OUT;
            end
            RD_OUT: begin
                core_oe   = 1'b1;
                core_addr = rd_addr;
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (rd_cnt_reg == 5'd31) begin
                        state_next = RELEASE;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 5'd1;
                        state_next  = RD_ADDR;
                    end
                end
            end
            RELEASE: begin
                // Dropping oe for a cycle hands the core back to its write state.
                rd_cnt_next = '0;
                state_next  = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// tb_rsa_host_ctrl: scoreboard bench for rsa_host_ctrl with a behavioural
// stand-in for the RSA core (small-operand modular exponentiation).
module tb_rsa_host_ctrl;

    localparam int LAT_W = 24;
`ifdef RSA_HOST_BIG_ENDIAN_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic [LAT_W-1:0] lat_cycles;
    logic             core_we, core_oe, core_start;
    logic [1:0]       core_reg_sel;
    logic [4:0]       core_addr;
    logic [7:0]       core_wdata;
    logic [7:0]       core_rdata;
    logic             core_ready;

    rsa_host_ctrl #(.LAT_W(LAT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .lat_cycles(lat_cycles),
        .core_we(core_we), .core_oe(core_oe), .core_start(core_start),
        .core_reg_sel(core_reg_sel), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    logic [14:0] wr_q[$];   // {reg_sel, addr, data}
    logic [8:0]  out_q[$];  // {last, data}
    int  done_cnt = 0;
    int  meas_lat = 0;
    int  rx_idx = 0;
    int  cyc = 0;
    int  next_lat = 10;
    bit  glitch_en = 1'b0;
    int  bp_mode = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference arithmetic: base^exp mod n with plain 64-bit math (n < 2^32).
    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
        logic [63:0] r, bb, ee;
        if (n < 2) return 64'd0;
        r = 1; bb = b % n; ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % n;
            bb = (bb * bb) % n;
            ee = ee >> 1;
        end
        return r;
    endfunction

    // ---------------- stand-in RSA core ----------------
    logic [7:0] cmem [0:3][0:31];
    logic [7:0] cres [0:31];
    int busy_cnt;

    function automatic logic [63:0] reg_val(input int r);
        logic [63:0] v;
        v = 0;
        for (int k = 7; k >= 0; k--) v = (v << 8) | 64'(cmem[r][k]);
        return v;
    endfunction

    function automatic logic [63:0] core_result();
        return modexp(reg_val(1), reg_val(2), reg_val(3));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            core_ready <= 1'b1;
            busy_cnt   <= 0;
            core_rdata <= 8'h00;
        end else begin
            if (core_we) cmem[core_reg_sel][core_addr] <= core_wdata;
            if (core_oe) core_rdata <= cres[core_addr];
            else         core_rdata <= 8'($urandom);
            if (core_start) begin
                core_ready <= 1'b0;
                busy_cnt   <= next_lat;
                for (int k = 0; k < 32; k++)
                    cres[k] <= (k < 8) ? 8'(core_result() >> (8 * k)) : 8'h00;
            end else if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt   <= 0;
                core_ready <= 1'b1;
            end else begin
                core_ready <= glitch_en ? ($urandom_range(0, 5) != 0) : 1'b1;
            end
        end
    end

    // ---------------- write / start monitor ----------------
    initial begin
        int we_cnt;
        int t0;
        bit lat_wait;
        logic [14:0] e;
        we_cnt = 0; t0 = 0; lat_wait = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                we_cnt = 0; lat_wait = 0;
            end else begin
                if (core_we) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", {core_reg_sel, core_addr, core_wdata}, 64'hFFFF);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_sel_addr_data", {core_reg_sel, core_addr, core_wdata}, e);
                    end
                    check("we_needs_valid_ready", {in_valid, core_ready}, 2'b11);
                    we_cnt++;
                end
                if (core_start) begin
                    check("start_we", core_we, 0);
                    check("we_count", we_cnt, 96);
                    we_cnt = 0; t0 = cyc; lat_wait = 1;
                end else if (lat_wait && core_ready && cyc > t0) begin
                    meas_lat = cyc - t0;
                    lat_wait = 0;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        bit rd_active;
        bit stall;
        logic [7:0] stall_data;
        logic [8:0] e;
        rd_active = 0; stall = 0; stall_data = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_active = 0; stall = 0; rx_idx = 0;
            end else begin
                if (rd_active) check("oe_continuous", core_oe, 1);
                if (core_oe) rd_active = 1;
                if (stall && out_valid) check("out_hold", out_data, stall_data);
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        check("out_unexpected", {out_last, out_data}, 64'hFFFF);
                    end else begin
                        e = out_q.pop_front();
                        check($sformatf("out_byte%0d", rx_idx), {out_last, out_data}, e);
                        check("oe_during_out", core_oe, 1);
                        rx_idx = (rx_idx + 1) % 32;
                        if (e[8]) begin
                            rd_active = 0;
                            done_cnt++;
                        end
                    end
                end
                stall = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        int hold_cnt;
        hold_cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rx_idx == 5 && hold_cnt < 13) begin
                        out_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (bp_mode != 2) hold_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n, input bit gap);
        logic [63:0] r;
        logic [31:0] v;
        logic [7:0]  byt;
        int sig;
        int w;
        bit hs;
        r = modexp(64'(b), 64'(e), 64'(n));
        for (int j = 0; j < 32; j++) begin
            sig = BE ? 31 - j : j;
            out_q.push_back({1'(j == 31), (sig < 8) ? 8'(r >> (8 * sig)) : 8'h00});
        end
        for (int i = 0; i < 96; i++) begin
            v   = (i < 32) ? b : (i < 64) ? e : n;
            sig = BE ? 31 - (i % 32) : (i % 32);
            byt = (sig < 4) ? 8'(v >> (8 * sig)) : 8'h00;
            wr_q.push_back({2'(i / 32 + 1), 5'(sig), byt});
            in_valid = 1'b1;
            in_data  = byt;
            w = 0;
            do begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!hs && w < 400);
            if (!hs) begin
                check("in_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int c;
        c = 0;
        while (done_cnt < target && c < 30000) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("job_done", done_cnt >= target, 1);
        check("lat_cycles", lat_cycles, meas_lat);
        check("out_q_drained", out_q.size(), 0);
    endtask

    task automatic run_job(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n,
                           input bit gap, input int lat);
        int target;
        next_lat = lat;
        target = done_cnt + 1;
        send_job(b, e, n, gap);
        wait_done(target);
    endtask

    initial begin
        logic [31:0] rn, rb, re;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_lat", lat_cycles, 0);
        check("rst_we", core_we, 0);
        check("rst_oe", core_oe, 0);
        check("rst_start", core_start, 0);
        check("rst_reg_sel", core_reg_sel, 2'b01);
        check("rst_addr", core_addr, BE ? 5'd31 : 5'd0);
        check("rst_wdata", core_wdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic job, then with input gaps, then with output backpressure.
        run_job(32'd4, 32'd13, 32'd497, 1'b0, 12);
        run_job(32'd4, 32'd13, 32'd497, 1'b1, 5);
        bp_mode = 2;
        run_job(32'd4, 32'd13, 32'd497, 1'b0, 9);
        bp_mode = 0;

        // Reset while the core is still computing.
        next_lat = 60;
        send_job(32'd4, 32'd13, 32'd497, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_q.delete();
        wr_q.delete();
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_strobes", {core_we, core_oe, core_start}, 3'b000);
        check("midrst_lat", lat_cycles, 0);
        @(posedge clk);
        #1;
        run_job(32'd4, 32'd13, 32'd497, 1'b0, 7);

        // Randomized jobs with ready glitches and random backpressure.
        glitch_en = 1'b1;
        bp_mode = 1;
        for (int j = 0; j < 5; j++) begin
            rn = 32'($urandom_range(2, 32'hFFFF_FFFF));
            rb = 32'($urandom) % rn;
            re = 32'($urandom);
            run_job(rb, re, rn, 1'($urandom_range(0, 1)), $urandom_range(2, 40));
        end
        glitch_en = 1'b0;
        bp_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
